// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receiver state encoding,
// common to uart_rx, uart_tx and the baud generator.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input; both flops reset to 1
// so a released reset never looks like a falling edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection with glitch rejection, LSB-first
// data capture, stop-bit checking and a break state that waits out a held-low line.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS) + 1;

  localparam logic [TICK_W-1:0] MID_START = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rx_state_t             state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  rx_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Strobes default low every clk; everything else only moves on os_tick.
  // rx_busy is written alongside each state change so it tracks the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (os_tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              rx_busy  <= 1'b1;
            end
          end

          START: begin
            if (tick_cnt == MID_START) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (tick_cnt == LAST_TICK) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              tick_cnt  <= '0;
              if (bit_idx == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          STOP: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (rx_s) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                state    <= IDLE;
                rx_busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          BREAK: begin
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end

          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // A completed byte and a framing error come from opposite stop-bit values.
  a_strobe_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(rx_valid && frame_err));

  a_valid_not_busy : assert property (@(posedge clk) disable iff (!rst_n)
    rx_valid |-> !rx_busy);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frames are described as bytes plus a
// stop-bit outcome, and a byte/error scoreboard predicts what the receiver reports.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       os_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int n_vectors = 0;
  int n_miscompares = 0;

  int tick_div = 4;
  int tick_ctr = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int exp_err = 0;
  int got_err = 0;
  int checked = 0;
  int busy_clks = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .os_tick   (os_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Baud-generator stand-in: one os_tick every tick_div clks (every clk when 1).
  always @(negedge clk) begin
    if (tick_ctr >= tick_div - 1) begin
      tick_ctr <= 0;
      os_tick  <= 1'b1;
    end else begin
      tick_ctr <= tick_ctr + 1;
      os_tick  <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, well away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        got_q.push_back(rx_data);
        checkOutput("busy_low_on_valid", 32'(rx_busy), 32'd0);
      end
      if (frame_err) got_err++;
      if (rx_busy) busy_clks++;
    end
  end

  task automatic drive(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  // One frame driven by clk count; a bad stop holds the line low for low_bits bit times.
  task automatic applyStimulus(input logic [7:0] d, input bit stop_ok, input int low_bits);
    int b;
    b = 16 * tick_div;
    drive(1'b0, b);
    for (int i = 0; i < 8; i++) drive(d[i], b);
    if (stop_ok) begin
      exp_q.push_back(d);
      last_good = d;
      drive(1'b1, b);
    end else begin
      exp_err++;
      drive(1'b0, b + b / 2);
      checkOutput("busy_in_break", 32'(rx_busy), 32'd1);
      checkOutput("data_kept_on_ferr", 32'(rx_data), 32'(last_good));
      drive(1'b0, (low_bits - 1) * b - b / 2);
      drive(1'b1, 2 * b);
    end
  endtask

  // Frame whose bit boundaries are counted in os_ticks, as uart_tx would emit it.
  task automatic send_via_tx(input logic [7:0] d);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      wait_ticks(16);
    end
    exp_q.push_back(d);
    last_good = d;
  endtask

  task automatic check_scoreboard(input string tag);
    drive(1'b1, 8);
    checkOutput({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = checked; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    checkOutput({tag, "_ferr"}, 32'(got_err), 32'(exp_err));
    checkOutput({tag, "_rx_data"}, 32'(rx_data), 32'(last_good));
    checkOutput({tag, "_idle"}, 32'(rx_busy), 32'd0);
    checked = exp_q.size();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy0;
    logic [7:0] d;

    repeat (5) @(negedge clk);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_rx_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 128);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, 0);
    check_scoreboard("frame_a5");

    $display("[TB] start-bit glitch then 0x3C");
    busy0 = busy_clks;
    drive(1'b0, 4 * tick_div);
    drive(1'b1, 4 * 16 * tick_div);
    checkOutput("glitch_busy_seen", 32'(busy_clks > busy0), 32'd1);
    checkOutput("glitch_back_idle", 32'(rx_busy), 32'd0);
    applyStimulus(8'h3C, 1'b1, 0);
    check_scoreboard("glitch");

    $display("[TB] framing error with held-low line");
    applyStimulus(8'h11, 1'b1, 0);
    applyStimulus(8'h3C, 1'b0, 3);
    applyStimulus(8'h7E, 1'b1, 0);
    check_scoreboard("ferr");

    $display("[TB] back-to-back frames");
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    check_scoreboard("b2b");

    $display("[TB] reset during data bit 4");
    d = 8'h5A;
    drive(1'b0, 64);
    for (int i = 0; i < 4; i++) drive(d[i], 64);
    drive(d[4], 32);
    checkOutput("busy_mid_frame", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("mid_rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("mid_rst_rx_busy", 32'(rx_busy), 32'd0);
    last_good = 8'h00;
    drive(1'b1, 4);
    rst_n = 1'b1;
    drive(1'b1, 128);
    applyStimulus(8'h81, 1'b1, 0);
    check_scoreboard("reset");

    $display("[TB] loopback-style frames locked to os_tick");
    wait_ticks(32);
    send_via_tx(8'h55);
    send_via_tx(8'hC3);
    check_scoreboard("loopback");

    $display("[TB] random frames");
    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 150));
      if (gap > 0) drive(1'b1, gap);
      applyStimulus(8'($urandom), $urandom_range(0, 4) != 0, int'($urandom_range(2, 3)));
    end
    check_scoreboard("random");

    $display("[TB] random frames with os_tick on consecutive clks");
    tick_div = 1;
    wait_ticks(32);
    for (int n = 0; n < 8; n++) send_via_tx(8'($urandom));
    tick_div = 2;
    wait_ticks(32);
    for (int n = 0; n < 8; n++) applyStimulus(8'($urandom), 1'b1, 0);
    check_scoreboard("fast_tick");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
